aes128_enc_iter: RTL and testbench

- Iterative AES-128 encryptor (FIPS-197): plaintext + cipher key in, ciphertext out; one round per clock, round keys expanded on the fly.
- Counterpart of the AES-128 decryptor in this design. It produces the ciphertext the decryptor consumes and uses the same 128-bit [0:127] bus convention.
- Valid/ready handshakes on input and output, so it can sit between a block source and the decryptor, or a result FIFO.

---
 rtl/aes128_pkg.sv | 42 ++++
 rtl/aes_sbox.sv | 54 +++++
 rtl/aes128_enc_iter.sv | 169 ++++++++++++++++
 tb/tb_aes128_enc_iter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/aes128_pkg.sv
// ============================================================================
// Module  : aes128_pkg
// Brief   : Shared constants, FSM states and GF(2^8) helpers for AES-128.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package aes128_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Byte k of the [0:127] bus sits at row k%4, column k/4.
    function automatic int byte_idx(input int row, input int col);
        return 4 * col + row;
    endfunction

    function automatic logic [7:0] get_byte(input logic [0:127] s, input int k);
        return s[8*k +: 8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// Module  : aes_sbox
// Brief   : Combinational AES forward S-box, 8 bit in, 8 bit out.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        case (x)
            8'h00: y = 8'h63; 8'h01: y = 8'h7c; 8'h02: y = 8'h77; 8'h03: y = 8'h7b; 8'h04: y = 8'hf2; 8'h05: y = 8'h6b; 8'h06: y = 8'h6f; 8'h07: y = 8'hc5;
            8'h08: y = 8'h30; 8'h09: y = 8'h01; 8'h0a: y = 8'h67; 8'h0b: y = 8'h2b; 8'h0c: y = 8'hfe; 8'h0d: y = 8'hd7; 8'h0e: y = 8'hab; 8'h0f: y = 8'h76;
            8'h10: y = 8'hca; 8'h11: y = 8'h82; 8'h12: y = 8'hc9; 8'h13: y = 8'h7d; 8'h14: y = 8'hfa; 8'h15: y = 8'h59; 8'h16: y = 8'h47; 8'h17: y = 8'hf0;
            8'h18: y = 8'had; 8'h19: y = 8'hd4; 8'h1a: y = 8'ha2; 8'h1b: y = 8'haf; 8'h1c: y = 8'h9c; 8'h1d: y = 8'ha4; 8'h1e: y = 8'h72; 8'h1f: y = 8'hc0;
            8'h20: y = 8'hb7; 8'h21: y = 8'hfd; 8'h22: y = 8'h93; 8'h23: y = 8'h26; 8'h24: y = 8'h36; 8'h25: y = 8'h3f; 8'h26: y = 8'hf7; 8'h27: y = 8'hcc;
            8'h28: y = 8'h34; 8'h29: y = 8'ha5; 8'h2a: y = 8'he5; 8'h2b: y = 8'hf1; 8'h2c: y = 8'h71; 8'h2d: y = 8'hd8; 8'h2e: y = 8'h31; 8'h2f: y = 8'h15;
            8'h30: y = 8'h04; 8'h31: y = 8'hc7; 8'h32: y = 8'h23; 8'h33: y = 8'hc3; 8'h34: y = 8'h18; 8'h35: y = 8'h96; 8'h36: y = 8'h05; 8'h37: y = 8'h9a;
            8'h38: y = 8'h07; 8'h39: y = 8'h12; 8'h3a: y = 8'h80; 8'h3b: y = 8'he2; 8'h3c: y = 8'heb; 8'h3d: y = 8'h27; 8'h3e: y = 8'hb2; 8'h3f: y = 8'h75;
            8'h40: y = 8'h09; 8'h41: y = 8'h83; 8'h42: y = 8'h2c; 8'h43: y = 8'h1a; 8'h44: y = 8'h1b; 8'h45: y = 8'h6e; 8'h46: y = 8'h5a; 8'h47: y = 8'ha0;
            8'h48: y = 8'h52; 8'h49: y = 8'h3b; 8'h4a: y = 8'hd6; 8'h4b: y = 8'hb3; 8'h4c: y = 8'h29; 8'h4d: y = 8'he3; 8'h4e: y = 8'h2f; 8'h4f: y = 8'h84;
            8'h50: y = 8'h53; 8'h51: y = 8'hd1; 8'h52: y = 8'h00; 8'h53: y = 8'hed; 8'h54: y = 8'h20; 8'h55: y = 8'hfc; 8'h56: y = 8'hb1; 8'h57: y = 8'h5b;
            8'h58: y = 8'h6a; 8'h59: y = 8'hcb; 8'h5a: y = 8'hbe; 8'h5b: y = 8'h39; 8'h5c: y = 8'h4a; 8'h5d: y = 8'h4c; 8'h5e: y = 8'h58; 8'h5f: y = 8'hcf;
            8'h60: y = 8'hd0; 8'h61: y = 8'hef; 8'h62: y = 8'haa; 8'h63: y = 8'hfb; 8'h64: y = 8'h43; 8'h65: y = 8'h4d; 8'h66: y = 8'h33; 8'h67: y = 8'h85;
            8'h68: y = 8'h45; 8'h69: y = 8'hf9; 8'h6a: y = 8'h02; 8'h6b: y = 8'h7f; 8'h6c: y = 8'h50; 8'h6d: y = 8'h3c; 8'h6e: y = 8'h9f; 8'h6f: y = 8'ha8;
            8'h70: y = 8'h51; 8'h71: y = 8'ha3; 8'h72: y = 8'h40; 8'h73: y = 8'h8f; 8'h74: y = 8'h92; 8'h75: y = 8'h9d; 8'h76: y = 8'h38; 8'h77: y = 8'hf5;
            8'h78: y = 8'hbc; 8'h79: y = 8'hb6; 8'h7a: y = 8'hda; 8'h7b: y = 8'h21; 8'h7c: y = 8'h10; 8'h7d: y = 8'hff; 8'h7e: y = 8'hf3; 8'h7f: y = 8'hd2;
            8'h80: y = 8'hcd; 8'h81: y = 8'h0c; 8'h82: y = 8'h13; 8'h83: y = 8'hec; 8'h84: y = 8'h5f; 8'h85: y = 8'h97; 8'h86: y = 8'h44; 8'h87: y = 8'h17;
            8'h88: y = 8'hc4; 8'h89: y = 8'ha7; 8'h8a: y = 8'h7e; 8'h8b: y = 8'h3d; 8'h8c: y = 8'h64; 8'h8d: y = 8'h5d; 8'h8e: y = 8'h19; 8'h8f: y = 8'h73;
            8'h90: y = 8'h60; 8'h91: y = 8'h81; 8'h92: y = 8'h4f; 8'h93: y = 8'hdc; 8'h94: y = 8'h22; 8'h95: y = 8'h2a; 8'h96: y = 8'h90; 8'h97: y = 8'h88;
            8'h98: y = 8'h46; 8'h99: y = 8'hee; 8'h9a: y = 8'hb8; 8'h9b: y = 8'h14; 8'h9c: y = 8'hde; 8'h9d: y = 8'h5e; 8'h9e: y = 8'h0b; 8'h9f: y = 8'hdb;
            8'ha0: y = 8'he0; 8'ha1: y = 8'h32; 8'ha2: y = 8'h3a; 8'ha3: y = 8'h0a; 8'ha4: y = 8'h49; 8'ha5: y = 8'h06; 8'ha6: y = 8'h24; 8'ha7: y = 8'h5c;
            8'ha8: y = 8'hc2; 8'ha9: y = 8'hd3; 8'haa: y = 8'hac; 8'hab: y = 8'h62; 8'hac: y = 8'h91; 8'had: y = 8'h95; 8'hae: y = 8'he4; 8'haf: y = 8'h79;
            8'hb0: y = 8'he7; 8'hb1: y = 8'hc8; 8'hb2: y = 8'h37; 8'hb3: y = 8'h6d; 8'hb4: y = 8'h8d; 8'hb5: y = 8'hd5; 8'hb6: y = 8'h4e; 8'hb7: y = 8'ha9;
            8'hb8: y = 8'h6c; 8'hb9: y = 8'h56; 8'hba: y = 8'hf4; 8'hbb: y = 8'hea; 8'hbc: y = 8'h65; 8'hbd: y = 8'h7a; 8'hbe: y = 8'hae; 8'hbf: y = 8'h08;
            8'hc0: y = 8'hba; 8'hc1: y = 8'h78; 8'hc2: y = 8'h25; 8'hc3: y = 8'h2e; 8'hc4: y = 8'h1c; 8'hc5: y = 8'ha6; 8'hc6: y = 8'hb4; 8'hc7: y = 8'hc6;
            8'hc8: y = 8'he8; 8'hc9: y = 8'hdd; 8'hca: y = 8'h74; 8'hcb: y = 8'h1f; 8'hcc: y = 8'h4b; 8'hcd: y = 8'hbd; 8'hce: y = 8'h8b; 8'hcf: y = 8'h8a;
            8'hd0: y = 8'h70; 8'hd1: y = 8'h3e; 8'hd2: y = 8'hb5; 8'hd3: y = 8'h66; 8'hd4: y = 8'h48; 8'hd5: y = 8'h03; 8'hd6: y = 8'hf6; 8'hd7: y = 8'h0e;
            8'hd8: y = 8'h61; 8'hd9: y = 8'h35; 8'hda: y = 8'h57; 8'hdb: y = 8'hb9; 8'hdc: y = 8'h86; 8'hdd: y = 8'hc1; 8'hde: y = 8'h1d; 8'hdf: y = 8'h9e;
            8'he0: y = 8'he1; 8'he1: y = 8'hf8; 8'he2: y = 8'h98; 8'he3: y = 8'h11; 8'he4: y = 8'h69; 8'he5: y = 8'hd9; 8'he6: y = 8'h8e; 8'he7: y = 8'h94;
            8'he8: y = 8'h9b; 8'he9: y = 8'h1e; 8'hea: y = 8'h87; 8'heb: y = 8'he9; 8'hec: y = 8'hce; 8'hed: y = 8'h55; 8'hee: y = 8'h28; 8'hef: y = 8'hdf;
            8'hf0: y = 8'h8c; 8'hf1: y = 8'ha1; 8'hf2: y = 8'h89; 8'hf3: y = 8'h0d; 8'hf4: y = 8'hbf; 8'hf5: y = 8'he6; 8'hf6: y = 8'h42; 8'hf7: y = 8'h68;
            8'hf8: y = 8'h41; 8'hf9: y = 8'h99; 8'hfa: y = 8'h2d; 8'hfb: y = 8'h0f; 8'hfc: y = 8'hb0; 8'hfd: y = 8'h54; 8'hfe: y = 8'hbb; 8'hff: y = 8'h16;
            default: y = 8'h00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/aes128_enc_iter.sv
// ============================================================================
// Module  : aes128_enc_iter
// Brief   : Iterative AES-128 encryptor, one round per clock, on-the-fly keys.
//           Optional AES128_ENC_LASTKEY_OUT_EN exports round key 10 as last_key.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module aes128_enc_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] key,
    input  logic [0:127] inText,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] outText,
    output logic         busy
`ifdef AES128_ENC_LASTKEY_OUT_EN
    ,
    output logic [0:127] last_key
`endif
);

    import aes128_pkg::*;

    generate
        if (NR != 10 || NR != aes128_pkg::NR) begin : g_nr_check
            $error("aes128_enc_iter: NR must be 10 for AES-128");
        end
    endgenerate

    aes_state_t   state;
    aes_state_t   state_nxt;
    logic [0:127] st;
    logic [0:127] rk;
    logic [0:127] sb;
    logic [0:127] sr;
    logic [0:127] mc;
    logic [0:127] rk_next;
    logic [0:127] round_out;
    logic [0:31]  sw;
    logic [7:0]   rcon;
    logic [3:0]   rnd;
    logic         accept;
    logic         last_round;

    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*byte_idx(r, c) +: 8] = get_byte(s, byte_idx(r, (c + r) % 4));
        return o;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_byte(s, byte_idx(0, c));
            a1 = get_byte(s, byte_idx(1, c));
            a2 = get_byte(s, byte_idx(2, c));
            a3 = get_byte(s, byte_idx(3, c));
            o[8*byte_idx(0, c) +: 8] = gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3;
            o[8*byte_idx(1, c) +: 8] = a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3;
            o[8*byte_idx(2, c) +: 8] = a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3);
            o[8*byte_idx(3, c) +: 8] = gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3);
        end
        return o;
    endfunction

    // sub_rot is SubWord(RotWord(w3)), supplied by the key-path S-boxes.
    function automatic logic [0:127] key_expand(input logic [0:127] k,
                                                input logic [0:31]  sub_rot,
                                                input logic [7:0]   rc);
        logic [0:31]  w [NK];
        logic [0:127] o;
        for (int i = 0; i < NK; i++) w[i] = k[32*i +: 32];
        w[0] = w[0] ^ sub_rot ^ {rc, 24'h000000};
        for (int i = 1; i < NK; i++) w[i] = w[i] ^ w[i-1];
        for (int i = 0; i < NK; i++) o[32*i +: 32] = w[i];
        return o;
    endfunction

    generate
        for (genvar i = 0; i < 16; i++) begin : g_state_sbox
            aes_sbox u_sbox (.x(st[8*i +: 8]), .y(sb[8*i +: 8]));
        end
        for (genvar i = 0; i < 4; i++) begin : g_key_sbox
            aes_sbox u_sbox (.x(rk[8*(12 + ((i + 1) % 4)) +: 8]), .y(sw[8*i +: 8]));
        end
    endgenerate

    assign sr         = shift_rows(sb);
    assign mc         = mix_columns(sr);
    assign rk_next    = key_expand(rk, sw, rcon);
    assign last_round = (rnd == 4'(NR));
    assign round_out  = (last_round ? sr : mc) ^ rk_next;
    assign accept     = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~reset;
                if (accept) state_nxt = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (last_round) state_nxt = DONE;
            end
            DONE: begin
                in_ready = out_ready & ~reset;
                if (accept)         state_nxt = ROUND;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= '0;
            rk        <= '0;
            rnd       <= 4'd0;
            rcon      <= 8'h01;
            out_valid <= 1'b0;
            outText   <= '0;
`ifdef AES128_ENC_LASTKEY_OUT_EN
            last_key  <= '0;
`endif
        end else begin
            if (state == DONE && out_ready) out_valid <= 1'b0;
            if (accept) begin
                st   <= inText ^ key;
                rk   <= key;
                rnd  <= 4'd1;
                rcon <= 8'h01;
            end else if (state == ROUND) begin
                st   <= round_out;
                rk   <= rk_next;
                rcon <= xtime(rcon);
                rnd  <= rnd + 4'd1;
                if (last_round) begin
                    outText   <= round_out;
                    out_valid <= 1'b1;
`ifdef AES128_ENC_LASTKEY_OUT_EN
                    last_key  <= rk_next;
`endif
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes128_enc_iter.sv
// ============================================================================
// Module  : tb_aes128_enc_iter
// Brief   : Scoreboard bench for aes128_enc_iter using FIPS-197 known answers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aes128_enc_iter;

    localparam logic [0:127] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C1_P  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] C1_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] B_P   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] B_C   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] B_LK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] Z_C   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] key;
    logic [0:127] inText;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] outText;
    logic         busy;
`ifdef AES128_ENC_LASTKEY_OUT_EN
    logic [0:127] last_key;
`endif

    int           errors = 0;
    int           checks = 0;
    logic [0:127] exp_q[$];
    logic [0:127] pending_exp;

    always #5 clk = ~clk;

    aes128_enc_iter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key       (key),
        .inText    (inText),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outText   (outText),
        .busy      (busy)
`ifdef AES128_ENC_LASTKEY_OUT_EN
        ,
        .last_key  (last_key)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Output handshake pops first so a same-cycle accept queues behind it.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_empty", 128'(exp_q.size()), 128'd1);
            else                   chk("ciphertext", outText, exp_q.pop_front());
        end
        if (!reset && in_valid && in_ready) exp_q.push_back(pending_exp);
    end

    task automatic start(input logic [0:127] k, input logic [0:127] p, input logic [0:127] e);
        logic acc;
        acc         = 1'b0;
        key         = k;
        inText      = p;
        pending_exp = e;
        in_valid    = 1'b1;
        for (int n = 0; n < 30 && !acc; n++) begin
            acc = in_ready;
            @(posedge clk); #1;
        end
        if (!acc) chk("accept_timeout", 128'd0, 128'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(tag, 128'(lat), 128'd10);
    endtask

    task automatic drain();
        @(posedge clk); #1;
        chk("idle_out_valid", 128'(out_valid), 128'd0);
        chk("idle_in_ready", 128'(in_ready), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [0:127] hold;
        int           lat;
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        key         = '0;
        inText      = '0;
        pending_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_outText", outText, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 128'(in_ready), 128'd1);

        // FIPS-197 C.1
        out_ready = 1'b1;
        start(C1_K, C1_P, C1_C);
        chk("c1_busy", 128'(busy), 128'd1);
        wait_out("c1_latency");
        drain();

        // All-zero block with the input ports churning during the rounds
        start('0, '0, Z_C);
        lat = 0;
        while (!out_valid && lat < 30) begin
            key    = {$urandom, $urandom, $urandom, $urandom};
            inText = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            lat++;
        end
        chk("zero_latency", 128'(lat), 128'd10);
        drain();

        // FIPS-197 Appendix B under backpressure, then back-to-back accept
        out_ready = 1'b0;
        start(B_K, B_P, B_C);
        wait_out("b_latency");
`ifdef AES128_ENC_LASTKEY_OUT_EN
        chk("b_last_key", last_key, B_LK);
`endif
        hold = outText;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_outText_stable", outText, hold);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready   = 1'b1;
        key         = '0;
        inText      = '0;
        pending_exp = Z_C;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_out_valid_drop", 128'(out_valid), 128'd0);
        chk("b2b_busy", 128'(busy), 128'd1);
        wait_out("b2b_latency");
        drain();

        // Reset while the C.1 block is in round 5
        start(C1_K, C1_P, C1_C);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_outText", outText, 128'd0);
        chk("abort_in_ready", 128'(in_ready), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("held_rst_in_ready", 128'(in_ready), 128'd0);
        end
        reset = 1'b0;
        #1;
        chk("rel_in_ready", 128'(in_ready), 128'd1);
        chk("rel_busy", 128'(busy), 128'd0);
        start(C1_K, C1_P, C1_C);
        wait_out("c1_again_latency");
        drain();

        chk("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
